// File: rtl/toy_amo_ctrl_if.sv
// Opcode/bus-op types and the request/response/bus interface of toy_amo_ctrl.
// The slave modport is the controller's view; master is the LSU/writeback/bus side.
package toy_amo_pkg;
  typedef enum logic [4:0] {
    AMOLR   = 5'd0,
    AMOSC   = 5'd1,
    AMOSWAP = 5'd2,
    AMOADD  = 5'd3,
    AMOXOR  = 5'd4,
    AMOAND  = 5'd5,
    AMOOR   = 5'd6,
    AMOMIN  = 5'd7,
    AMOMAX  = 5'd8,
    AMOMINU = 5'd9,
    AMOMAXU = 5'd10
  } amo_opcode_t;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } toy_bus_op_t;
endpackage

interface toy_amo_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import toy_amo_pkg::*;

  // req_op stays raw so undefined codes can reach the controller and be rejected
  logic                  req_vld;
  logic                  req_rdy;
  logic [4:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [4:0]            req_rd;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [4:0]            rsp_rd;
  logic                  rsp_err;

  logic                  bus_req_vld;
  logic                  bus_req_rdy;
  toy_bus_op_t           bus_req_op;
  logic [ADDR_WIDTH-1:0] bus_req_addr;
  logic [DATA_WIDTH-1:0] bus_req_wdata;
  logic                  bus_ack_vld;
  logic [DATA_WIDTH-1:0] bus_ack_rdata;

  modport master (
    output req_vld, req_op, req_addr, req_data, req_rd, rsp_rdy,
           bus_req_rdy, bus_ack_vld, bus_ack_rdata,
    input  req_rdy, rsp_vld, rsp_data, rsp_rd, rsp_err,
           bus_req_vld, bus_req_op, bus_req_addr, bus_req_wdata
  );

  modport slave (
    input  req_vld, req_op, req_addr, req_data, req_rd, rsp_rdy,
           bus_req_rdy, bus_ack_vld, bus_ack_rdata,
    output req_rdy, rsp_vld, rsp_data, rsp_rd, rsp_err,
           bus_req_vld, bus_req_op, bus_req_addr, bus_req_wdata
  );
endinterface

// File: rtl/toy_amo_ctrl.sv
// Single-outstanding atomic memory operation controller (read / calc / write / respond).
// Define TOY_AMO_LRSC_EN to add the LR/SC reservation; otherwise LR and SC are rejected.
module toy_amo_ctrl
  import toy_amo_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  toy_amo_ctrl_if.slave         amo,
  input  logic                  snoop_wr_vld,
  input  logic [ADDR_WIDTH-1:0] snoop_wr_addr,
  input  logic                  resv_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CALC, S_WR_REQ, S_WR_WAIT, S_RSP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [4:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [4:0]            r_rd;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_unsupported;
  logic                  w_reject;
  logic                  w_sc_ok;
  logic [DATA_WIDTH-1:0] w_new;

  assign w_accept      = amo.req_vld && (r_state == S_IDLE);
  assign w_misaligned  = amo.req_addr[1:0] != 2'b00;
  assign w_unsupported = amo.req_op > AMOMAXU;

`ifdef TOY_AMO_LRSC_EN
  logic                  r_resv_vld;
  logic [ADDR_WIDTH-3:0] r_resv_word;
  logic                  w_resv_hit;
  logic                  w_resv_set;
  logic                  w_snoop_hit;
  logic                  w_resv_clr;

  assign w_reject   = w_misaligned || w_unsupported;
  assign w_resv_hit = r_resv_vld && (r_resv_word == r_addr[ADDR_WIDTH-1:2]);
  assign w_sc_ok    = w_resv_hit;
  assign w_resv_set = (r_state == S_RD_WAIT) && amo.bus_ack_vld && (r_op == AMOLR);
  // A snoop in the LR ack cycle must be compared against the word being reserved
  assign w_snoop_hit = snoop_wr_vld &&
    (snoop_wr_addr[ADDR_WIDTH-1:2] == (w_resv_set ? r_addr[ADDR_WIDTH-1:2] : r_resv_word));
  assign w_resv_clr = resv_clr || w_snoop_hit ||
                      ((r_state == S_CALC) && ((r_op == AMOSC) || w_resv_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resv_vld  <= 1'b0;
      r_resv_word <= '0;
    end else if (w_resv_clr) begin
      r_resv_vld  <= 1'b0;
    end else if (w_resv_set) begin
      r_resv_vld  <= 1'b1;
      r_resv_word <= r_addr[ADDR_WIDTH-1:2];
    end
  end
`else
  logic w_unused_lrsc;

  assign w_reject      = w_misaligned || w_unsupported ||
                         (amo.req_op == AMOLR) || (amo.req_op == AMOSC);
  assign w_sc_ok       = 1'b0;
  assign w_unused_lrsc = ^{snoop_wr_vld, snoop_wr_addr, resv_clr};
`endif

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject)                   w_next_state = S_RSP;
          else if (amo.req_op == AMOSC)   w_next_state = S_CALC;
          else                            w_next_state = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (amo.bus_req_rdy) w_next_state = S_RD_WAIT;
      S_RD_WAIT: if (amo.bus_ack_vld) w_next_state = (r_op == AMOLR) ? S_RSP : S_CALC;
      S_CALC:    w_next_state = ((r_op == AMOSC) && !w_sc_ok) ? S_RSP : S_WR_REQ;
      S_WR_REQ:  if (amo.bus_req_rdy) w_next_state = S_WR_WAIT;
      S_WR_WAIT: if (amo.bus_ack_vld) w_next_state = S_RSP;
      S_RSP:     if (amo.rsp_rdy)     w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_new = r_data;
    case (r_op)
      AMOADD:  w_new = r_rsp_data + r_data;
      AMOXOR:  w_new = r_rsp_data ^ r_data;
      AMOAND:  w_new = r_rsp_data & r_data;
      AMOOR:   w_new = r_rsp_data | r_data;
      AMOMIN:  w_new = ($signed(r_data) < $signed(r_rsp_data)) ? r_data : r_rsp_data;
      AMOMAX:  w_new = ($signed(r_data) > $signed(r_rsp_data)) ? r_data : r_rsp_data;
      AMOMINU: w_new = (r_data < r_rsp_data) ? r_data : r_rsp_data;
      AMOMAXU: w_new = (r_data > r_rsp_data) ? r_data : r_rsp_data;
      default: w_new = r_data;
    endcase
  end

  // r_rsp_data holds the old memory value, which is both the calc operand and the rd result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd       <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= amo.req_op;
        r_addr     <= amo.req_addr;
        r_data     <= amo.req_data;
        r_rd       <= amo.req_rd;
        r_err      <= w_reject;
        r_rsp_data <= '0;
      end
      if ((r_state == S_RD_WAIT) && amo.bus_ack_vld) r_rsp_data <= amo.bus_ack_rdata;
      if (r_state == S_CALC) begin
        r_wdata <= w_new;
        if (r_op == AMOSC) r_rsp_data <= {{(DATA_WIDTH-1){1'b0}}, !w_sc_ok};
      end
    end
  end

  always_comb begin
    amo.req_rdy       = 1'b0;
    amo.rsp_vld       = 1'b0;
    amo.rsp_data      = '0;
    amo.rsp_rd        = '0;
    amo.rsp_err       = 1'b0;
    amo.bus_req_vld   = 1'b0;
    amo.bus_req_op    = BUS_READ;
    amo.bus_req_addr  = '0;
    amo.bus_req_wdata = '0;
    case (r_state)
      S_IDLE: amo.req_rdy = 1'b1;
      S_RD_REQ: begin
        amo.bus_req_vld  = 1'b1;
        amo.bus_req_addr = r_addr;
      end
      S_WR_REQ: begin
        amo.bus_req_vld   = 1'b1;
        amo.bus_req_op    = BUS_WRITE;
        amo.bus_req_addr  = r_addr;
        amo.bus_req_wdata = r_wdata;
      end
      S_RSP: begin
        amo.rsp_vld  = 1'b1;
        amo.rsp_data = r_rsp_data;
        amo.rsp_rd   = r_rd;
        amo.rsp_err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_toy_amo_ctrl.sv
// Directed bench for toy_amo_ctrl: memory/reservation model plus per-cycle bus and response compare.
// Follows TOY_AMO_LRSC_EN the same way as the design.
module tb_toy_amo_ctrl;
  import toy_amo_pkg::*;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          lat;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic        snoop_wr_vld;
  logic [31:0] snoop_wr_addr;
  logic        resv_clr;

  toy_amo_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) amo_if ();

  toy_amo_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .amo           (amo_if),
    .snoop_wr_vld  (snoop_wr_vld),
    .snoop_wr_addr (snoop_wr_addr),
    .resv_clr      (resv_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bus_exp_t exp_bus[$];
  rsp_exp_t exp_rsp[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
`ifdef TOY_AMO_LRSC_EN
  bit          resv_valid = 1'b0;
  logic [29:0] resv_word  = '0;
`endif

  // bus responder controls
  bit          pend = 1'b0;
  bit          pend_wr = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          ack_delay = 0;
  int          rdy_stall = 0;
  bit          stray_ack = 1'b0;
  bit          snoop_arm = 1'b0;
  logic [31:0] snoop_arm_addr = '0;
  int          bus_vld_cycles = 0;

  int          rsp_hold = 0;
  int          acc_cyc = 0;
  bit          rsp_seen = 1'b0;
  logic [31:0] last_rsp_data = '0;
  logic        last_rsp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] amo_result(input logic [4:0] op, input logic [31:0] old,
                                             input logic [31:0] data);
    int signed so = old;
    int signed sd = data;
    case (op)
      AMOSWAP: return data;
      AMOADD:  return old + data;
      AMOXOR:  return old ^ data;
      AMOAND:  return old & data;
      AMOOR:   return old | data;
      AMOMIN:  return (sd < so) ? data : old;
      AMOMAX:  return (sd > so) ? data : old;
      AMOMINU: return (data < old) ? data : old;
      AMOMAXU: return (data > old) ? data : old;
      default: return old;
    endcase
  endfunction

  function automatic void model_op(input logic [4:0] op, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [4:0] rd, input bit chk_lat);
    logic [31:0] old;
    logic [31:0] nw;
    rsp_exp_t r;
    old    = mem_model.exists(addr) ? mem_model[addr] : 32'h0;
    r.rd   = rd;
    r.err  = 1'b0;
    r.data = 32'h0;
    r.lat  = 1;
    if (addr[1:0] != 2'b00 || op > 5'd10) begin
      r.err = 1'b1;
    end else if (op == AMOLR || op == AMOSC) begin
`ifdef TOY_AMO_LRSC_EN
      if (op == AMOLR) begin
        exp_bus.push_back('{BUS_READ, addr, 32'h0});
        r.data = old;
        r.lat  = 3;
        resv_valid = 1'b1;
        resv_word  = addr[31:2];
      end else begin
        if (resv_valid && resv_word == addr[31:2]) begin
          exp_bus.push_back('{BUS_WRITE, addr, data});
          mem_model[addr] = data;
          r.data = 32'h0;
          r.lat  = 4;
        end else begin
          r.data = 32'h1;
          r.lat  = 2;
        end
        resv_valid = 1'b0;
      end
`else
      r.err = 1'b1;
`endif
    end else begin
      nw = amo_result(op, old, data);
      exp_bus.push_back('{BUS_READ, addr, 32'h0});
      exp_bus.push_back('{BUS_WRITE, addr, nw});
      mem_model[addr] = nw;
      r.data = old;
      r.lat  = 6;
`ifdef TOY_AMO_LRSC_EN
      if (resv_valid && resv_word == addr[31:2]) resv_valid = 1'b0;
`endif
    end
    if (!chk_lat) r.lat = 0;
    exp_rsp.push_back(r);
  endfunction

  function automatic void model_snoop(input logic [31:0] addr);
`ifdef TOY_AMO_LRSC_EN
    if (resv_valid && resv_word == addr[31:2]) resv_valid = 1'b0;
`endif
  endfunction

  function automatic void model_clear();
`ifdef TOY_AMO_LRSC_EN
    resv_valid = 1'b0;
`endif
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    bus_mem[addr]   = val;
    mem_model[addr] = val;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: accepts per rdy_stall, acks ack_delay cycles after the handshake
  initial begin
    amo_if.bus_req_rdy   = 1'b1;
    amo_if.bus_ack_vld   = 1'b0;
    amo_if.bus_ack_rdata = '0;
    snoop_wr_vld         = 1'b0;
    snoop_wr_addr        = '0;
    forever begin
      @(posedge clk);
      #1;
      amo_if.bus_ack_vld   = 1'b0;
      amo_if.bus_ack_rdata = '0;
      snoop_wr_vld         = 1'b0;
      snoop_wr_addr        = '0;
      if (pend && pend_cnt == 0) begin
        amo_if.bus_ack_vld = 1'b1;
        if (!pend_wr) begin
          amo_if.bus_ack_rdata = bus_mem.exists(pend_addr) ? bus_mem[pend_addr] : 32'h0;
          if (snoop_arm) begin
            snoop_wr_vld  = 1'b1;
            snoop_wr_addr = snoop_arm_addr;
            snoop_arm     = 1'b0;
          end
        end
        pend = 1'b0;
      end else if (pend) begin
        pend_cnt--;
      end else if (stray_ack) begin
        amo_if.bus_ack_vld   = 1'b1;
        amo_if.bus_ack_rdata = 32'hDEAD_BEEF;
        stray_ack = 1'b0;
      end
      amo_if.bus_req_rdy = (amo_if.bus_req_vld && rdy_stall > 0) ? 1'b0 : 1'b1;
      if (amo_if.bus_req_vld && rdy_stall > 0) rdy_stall--;
      @(negedge clk);
      if (amo_if.bus_req_vld) bus_vld_cycles++;
      if (rst_n && amo_if.bus_req_vld && amo_if.bus_req_rdy) begin
        pend      = 1'b1;
        pend_cnt  = ack_delay;
        pend_wr   = (amo_if.bus_req_op == BUS_WRITE);
        pend_addr = amo_if.bus_req_addr;
        if (pend_wr) bus_mem[pend_addr] = amo_if.bus_req_wdata;
      end
    end
  end

  // Compare process: every cycle, bus request fields and response against the model queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (amo_if.req_vld && amo_if.req_rdy) acc_cyc = cyc;
      if (amo_if.bus_req_vld) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected_vld", amo_if.bus_req_vld, 1'b0);
        end else begin
          check("bus_op", amo_if.bus_req_op, exp_bus[0].op);
          check("bus_addr", amo_if.bus_req_addr, exp_bus[0].addr);
          if (exp_bus[0].op == BUS_WRITE) check("bus_wdata", amo_if.bus_req_wdata, exp_bus[0].wdata);
          if (amo_if.bus_req_rdy) void'(exp_bus.pop_front());
        end
      end
      if (amo_if.rsp_vld) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected_vld", amo_if.rsp_vld, 1'b0);
        end else begin
          if (!rsp_seen && exp_rsp[0].lat != 0) check("rsp_latency", cyc - acc_cyc, exp_rsp[0].lat);
          rsp_seen = 1'b1;
          check("rsp_data", amo_if.rsp_data, exp_rsp[0].data);
          check("rsp_rd", amo_if.rsp_rd, exp_rsp[0].rd);
          check("rsp_err", amo_if.rsp_err, exp_rsp[0].err);
          if (amo_if.rsp_rdy) begin
            last_rsp_data = amo_if.rsp_data;
            last_rsp_err  = amo_if.rsp_err;
            rsp_seen      = 1'b0;
            void'(exp_rsp.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd);
    bit got = 1'b0;
    amo_if.req_vld  = 1'b1;
    amo_if.req_op   = op;
    amo_if.req_addr = addr;
    amo_if.req_data = data;
    amo_if.req_rd   = rd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (amo_if.req_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("req_accept_timeout", amo_if.req_rdy, 1'b1);
    @(posedge clk);
    #1;
    amo_if.req_vld = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (exp_rsp.size() == 0) break;
      if (amo_if.rsp_vld && rsp_hold > 0) begin
        amo_if.rsp_rdy = 1'b0;
        rsp_hold--;
      end else begin
        amo_if.rsp_rdy = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("rsp_pending_at_end", exp_rsp.size(), 0);
    check("bus_pending_at_end", exp_bus.size(), 0);
    exp_rsp.delete();
    exp_bus.delete();
    rsp_seen = 1'b0;
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input bit chk_lat);
    model_op(op, addr, data, rd, chk_lat);
    issue(op, addr, data, rd);
    wait_done();
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] mem;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];
  int   v0;
  bit   got;

  initial begin
    vecs[0] = '{AMOMAX,  32'h310, 32'h8000_0000, 32'h0000_0001};
    vecs[1] = '{AMOMAXU, 32'h314, 32'h8000_0000, 32'h0000_0001};
    vecs[2] = '{AMOXOR,  32'h318, 32'hF0F0_1234, 32'h0FF0_FFFF};
    vecs[3] = '{AMOAND,  32'h31C, 32'hF0F0_1234, 32'h0FF0_FFFF};
    vecs[4] = '{AMOOR,   32'h320, 32'hF0F0_1234, 32'h0FF0_FFFF};
    vecs[5] = '{AMOSWAP, 32'h324, 32'h1111_2222, 32'h3333_4444};
    vecs[6] = '{AMOMIN,  32'h328, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    vecs[7] = '{AMOMAXU, 32'h32C, 32'h0000_0007, 32'hFFFF_FFFF};

    rst_n           = 1'b0;
    resv_clr        = 1'b0;
    amo_if.req_vld  = 1'b0;
    amo_if.req_op   = '0;
    amo_if.req_addr = '0;
    amo_if.req_data = '0;
    amo_if.req_rd   = '0;
    amo_if.rsp_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_rdy", amo_if.req_rdy, 1'b1);
    check("reset_bus_req_vld", amo_if.bus_req_vld, 1'b0);
    check("reset_rsp_vld", amo_if.rsp_vld, 1'b0);
    check("reset_rsp_err", amo_if.rsp_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    preload(32'h100, 32'hFFFF_FFFE);
    do_op(AMOADD, 32'h100, 32'd5, 5'd3, 1'b1);
    check("add_mem", bus_mem[32'h100], 32'h0000_0003);
    check("add_rsp_data", last_rsp_data, 32'hFFFF_FFFE);
    check("add_rsp_err", last_rsp_err, 1'b0);

    preload(32'h300, 32'h8000_0000);
    do_op(AMOMIN, 32'h300, 32'h1, 5'd4, 1'b1);
    check("min_mem", bus_mem[32'h300], 32'h8000_0000);
    check("min_rsp_data", last_rsp_data, 32'h8000_0000);
    preload(32'h300, 32'h8000_0000);
    do_op(AMOMINU, 32'h300, 32'h1, 5'd5, 1'b1);
    check("minu_mem", bus_mem[32'h300], 32'h0000_0001);
    check("minu_rsp_data", last_rsp_data, 32'h8000_0000);

    foreach (vecs[i]) begin
      preload(vecs[i].addr, vecs[i].mem);
      do_op(vecs[i].op, vecs[i].addr, vecs[i].data, 5'(i + 16), 1'b1);
    end
    check("xor_mem", bus_mem[32'h318], 32'hFF00_EDCB);

    v0 = bus_vld_cycles;
    do_op(AMOSWAP, 32'h102, 32'hAA, 5'd7, 1'b1);
    check("misaligned_bus_cycles", bus_vld_cycles - v0, 0);
    check("misaligned_rsp_err", last_rsp_err, 1'b1);
    check("misaligned_rsp_data", last_rsp_data, 32'h0);

    do_op(5'd20, 32'h104, 32'h1, 5'd8, 1'b1);
    check("unsupported_rsp_err", last_rsp_err, 1'b1);

    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload(32'h108, 32'h10);
    do_op(AMOADD, 32'h108, 32'h1, 5'd9, 1'b1);
    check("after_stray_ack_mem", bus_mem[32'h108], 32'h11);

    preload(32'h200, 32'h55);
    do_op(AMOLR, 32'h200, 32'h0, 5'd10, 1'b1);
`ifdef TOY_AMO_LRSC_EN
    check("lr_rsp_data", last_rsp_data, 32'h55);
`else
    check("lr_disabled_err", last_rsp_err, 1'b1);
`endif
    do_op(AMOSC, 32'h200, 32'h77, 5'd11, 1'b1);
    v0 = bus_vld_cycles;
    do_op(AMOSC, 32'h200, 32'h88, 5'd12, 1'b1);
    check("sc2_bus_cycles", bus_vld_cycles - v0, 0);
`ifdef TOY_AMO_LRSC_EN
    check("sc1_mem", bus_mem[32'h200], 32'h77);
    check("sc2_rsp_data", last_rsp_data, 32'h1);
`else
    check("sc_disabled_mem", bus_mem[32'h200], 32'h55);
    check("sc_disabled_err", last_rsp_err, 1'b1);
`endif

    snoop_arm      = 1'b1;
    snoop_arm_addr = 32'h203;
    do_op(AMOLR, 32'h200, 32'h0, 5'd13, 1'b1);
    model_snoop(32'h203);
    snoop_arm = 1'b0;
    do_op(AMOSC, 32'h200, 32'h99, 5'd14, 1'b1);
`ifdef TOY_AMO_LRSC_EN
    check("snoop_sc_rsp_data", last_rsp_data, 32'h1);
    check("snoop_sc_mem", bus_mem[32'h200], 32'h77);
`endif

    preload(32'h208, 32'h1);
    do_op(AMOLR, 32'h208, 32'h0, 5'd15, 1'b1);
    resv_clr = 1'b1;
    @(posedge clk);
    #1;
    resv_clr = 1'b0;
    model_clear();
    do_op(AMOSC, 32'h208, 32'h2, 5'd16, 1'b1);

    preload(32'h20C, 32'h5);
    do_op(AMOLR, 32'h20C, 32'h0, 5'd17, 1'b1);
    do_op(AMOADD, 32'h20C, 32'h1, 5'd18, 1'b1);
    do_op(AMOSC, 32'h20C, 32'h9, 5'd19, 1'b1);
    check("amo_clears_resv_mem", bus_mem[32'h20C], 32'h6);

    preload(32'h500, 32'h3);
    do_op(AMOLR, 32'h500, 32'h0, 5'd20, 1'b1);
    preload(32'h400, 32'h10);
    rdy_stall = 10;
    rsp_hold  = 5;
    do_op(AMOOR, 32'h400, 32'h0F, 5'd21, 1'b0);
    check("stalled_or_mem", bus_mem[32'h400], 32'h1F);
    check("stalled_or_rsp", last_rsp_data, 32'h10);

    preload(32'h404, 32'h0F);
    ack_delay = 8;
    model_op(AMOXOR, 32'h404, 32'hF0, 5'd22, 1'b0);
    issue(AMOXOR, 32'h404, 32'hF0, 5'd22);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pend && pend_wr) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("wr_wait_timeout", pend, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_req_rdy", amo_if.req_rdy, 1'b1);
    check("midop_reset_bus_req_vld", amo_if.bus_req_vld, 1'b0);
    check("midop_reset_rsp_vld", amo_if.rsp_vld, 1'b0);
    check("midop_reset_rsp_data", amo_if.rsp_data, 32'h0);
    check("midop_reset_bus_addr", amo_if.bus_req_addr, 32'h0);
    exp_bus.delete();
    exp_rsp.delete();
    rsp_seen = 1'b0;
    model_clear();
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_reset_req_rdy", amo_if.req_rdy, 1'b1);
    check("post_reset_bus_req_vld", amo_if.bus_req_vld, 1'b0);
    check("late_ack_consumed", pend, 1'b0);

    do_op(AMOSC, 32'h500, 32'h44, 5'd23, 1'b1);
`ifdef TOY_AMO_LRSC_EN
    check("post_reset_sc_rsp", last_rsp_data, 32'h1);
`endif
    check("post_reset_sc_mem", bus_mem[32'h500], 32'h3);
    do_op(AMOADD, 32'h404, 32'h1, 5'd24, 1'b1);
    check("post_reset_add_rsp", last_rsp_data, 32'hFF);
    check("post_reset_add_mem", bus_mem[32'h404], 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
